// File: rtl/mac_array.sv
// mac_array: LANES-wide multiply-accumulate array producing OUTS dot products of TAPS terms per job.
// Optional macro MAC_SAT_EN: saturating accumulation with sticky per-lane overflow flags.

module mac_lane #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 7,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ovf_clr,
    input  logic              take,
    input  logic              last,
    input  logic [DATA_W-1:0] x,
    input  logic [COEF_W-1:0] c,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    localparam int PW = DATA_W + COEF_W;
`ifdef MAC_SAT_EN
    // One guard bit above the widest operand so the true sum is never lost.
    localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
`else
    localparam int SW = ACC_W;
`endif

    logic [ACC_W-1:0] acc;
    logic [SW-1:0]    full;
    logic             clamp;

    assign full = SW'(acc) + SW'(x) * SW'(c);

`ifdef MAC_SAT_EN
    assign clamp = full > SW'({ACC_W{1'b1}});
    assign sum   = clamp ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign clamp = 1'b0;
    assign sum   = full;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (take) begin
            acc <= last ? '0 : sum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end else if (take && clamp) begin
            ovf <= 1'b1;
        end
    end
endmodule

module mac_array #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 7,
    parameter int TAPS   = 8,
    parameter int OUTS   = 4,
    parameter int ACC_W  = 18,
    parameter int ROM_AW = 4,
    parameter int IDX_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    x_valid,
    input  logic [LANES*DATA_W-1:0] x_data,
    input  logic [2*COEF_W-1:0]     coef_word,
    output logic                    x_take,
    output logic [ROM_AW-1:0]       rom_addr,
    output logic [LANES*ACC_W-1:0]  res_data,
    output logic [IDX_W-1:0]        res_idx,
    output logic                    res_we,
    output logic                    busy,
    output logic                    done,
    output logic [LANES-1:0]        ovf
);
    localparam int TAP_W = (TAPS > 2) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(OUTS - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [TAP_W-1:0]              tap;
    logic [IDX_W-1:0]              res_cnt;
    logic [COEF_W-1:0]             coef;
    logic [LANES-1:0][ACC_W-1:0]   lane_sum;
    logic go, adv, tap_last, acc_end, job_end, lane_clr;

    assign busy     = (state == RUN);
    assign x_take   = busy && x_valid;
    assign go       = (state == IDLE) && start && !abort;
    assign adv      = x_take && !abort;
    assign tap_last = (tap == TAP_LAST);
    assign acc_end  = adv && tap_last;
    assign job_end  = acc_end && (res_cnt == OUT_LAST);
    assign lane_clr = go || (busy && abort);
    // Each ROM word carries an even/odd tap pair; tap parity picks the half.
    assign coef     = tap[0] ? coef_word[COEF_W-1:0] : coef_word[2*COEF_W-1:COEF_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = RUN;
            RUN:     if (abort || job_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap      <= '0;
            res_cnt  <= '0;
            rom_addr <= '0;
            res_data <= '0;
            res_idx  <= '0;
            res_we   <= 1'b0;
            done     <= 1'b0;
        end else begin
            res_we <= acc_end;
            done   <= job_end;
            if (go) begin
                tap      <= '0;
                res_cnt  <= '0;
                rom_addr <= '0;
            end else if (adv) begin
                tap <= tap_last ? '0 : tap + 1'b1;
                if (tap_last) res_cnt  <= res_cnt + 1'b1;
                if (tap[0])   rom_addr <= rom_addr + 1'b1;
            end
            if (acc_end) begin
                res_idx <= res_cnt;
                for (int i = 0; i < LANES; i++)
                    res_data[i*ACC_W +: ACC_W] <= lane_sum[i];
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (lane_clr),
            .ovf_clr (go),
            .take    (adv),
            .last    (tap_last),
            .x       (x_data[i*DATA_W +: DATA_W]),
            .c       (coef),
            .sum     (lane_sum[i]),
            .ovf     (ovf[i])
        );
    end
endmodule

// File: tb/tb_mac_array.sv
// Directed bench for mac_array: default instance plus an ACC_W=16 instance sharing stimulus.
module tb_mac_array;
    logic        clk = 1'b0;
    logic        rst, start, abort, x_valid;
    logic [31:0] x_data;
    logic [13:0] coef_word, coef_word16, coef_const;
    logic        rom_mode;
    logic        x_take, res_we, busy, done;
    logic [3:0]  rom_addr, ovf;
    logic [71:0] res_data;
    logic [1:0]  res_idx;
    logic        x_take16, res_we16, busy16, done16;
    logic [3:0]  rom_addr16, ovf16;
    logic [63:0] res_data16;
    logic [1:0]  res_idx16;

    int n_assert = 0, n_fail = 0;
    int cyc = 0, we_n, done_n, job_cyc, taken;
    logic [71:0] r_data [0:7];
    logic [63:0] r16    [0:7];
    logic [1:0]  r_idx  [0:7];
    logic        r_done [0:7];
    int          r_cyc  [0:7];
    logic [3:0]  ra     [0:63];
    logic        busy_at_done, busy_after_start;

`ifdef MAC_SAT_EN
    localparam logic [15:0] EXP16  = 16'hFFFF;
    localparam logic [3:0]  EXPOVF = 4'hF;
`else
    localparam logic [15:0] EXP16  = 16'd62472;
    localparam logic [3:0]  EXPOVF = 4'h0;
`endif

    always #5 clk = ~clk;

    always_comb begin
        coef_word   = rom_mode ? {7'(rom_addr), 7'd0}   : coef_const;
        coef_word16 = rom_mode ? {7'(rom_addr16), 7'd0} : coef_const;
    end

    mac_array u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x_valid(x_valid),
        .x_data(x_data), .coef_word(coef_word), .x_take(x_take), .rom_addr(rom_addr),
        .res_data(res_data), .res_idx(res_idx), .res_we(res_we), .busy(busy),
        .done(done), .ovf(ovf)
    );

    mac_array #(.ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x_valid(x_valid),
        .x_data(x_data), .coef_word(coef_word16), .x_take(x_take16), .rom_addr(rom_addr16),
        .res_data(res_data16), .res_idx(res_idx16), .res_we(res_we16), .busy(busy16),
        .done(done16), .ovf(ovf16)
    );

    function automatic logic [71:0] rep(input logic [17:0] v);
        return {4{v}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (res_we) begin
            if (we_n < 8) begin
                r_data[we_n] = res_data; r16[we_n] = res_data16;
                r_idx[we_n] = res_idx; r_done[we_n] = done; r_cyc[we_n] = cyc;
            end
            we_n++;
        end
        if (done) begin
            done_n++;
            busy_at_done = busy;
        end
    endtask

    // stall_at/abort_after/start_at are accepted-tap counts; -1 disables.
    task automatic run_job(input int stall_at, input int stall_len,
                           input int abort_after, input int start_at);
        int stalled = 0;
        int c0;
        we_n = 0; done_n = 0; taken = 0; busy_at_done = 1'b1;
        x_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0; c0 = cyc;
        busy_after_start = busy;
        for (int k = 0; k < 200; k++) begin
            x_valid = !(stall_at >= 0 && taken == stall_at && stalled < stall_len);
            if (!x_valid) stalled++;
            abort = (taken == abort_after);
            start = (taken == start_at);
            #1;
            if (x_take) taken++;
            step();
            if (k < 64) ra[k] = rom_addr;
            if (done || !busy) break;
        end
        abort = 1'b0; start = 1'b0; x_valid = 1'b0;
        job_cyc = cyc - c0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; x_valid = 1'b0;
        x_data = '0; coef_const = '0; rom_mode = 1'b0;
        #12;
        chk("reset_outputs", {rom_addr, res_idx, res_we, busy, done, ovf},
            {4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0});
        chk("reset_res_data", res_data, 72'd0);
        #10 rst = 1'b1;

        // All ones
        x_data = {4{8'd1}}; coef_const = {7'd1, 7'd1};
        run_job(-1, 0, -1, -1);
        chk("ones_busy_after_start", busy_after_start, 1'b1);
        chk("ones_we_count", we_n, 4);
        chk("ones_idx", {r_idx[0], r_idx[1], r_idx[2], r_idx[3]}, 8'b00_01_10_11);
        chk("ones_data", {r_data[0], r_data[1], r_data[2], r_data[3]},
            {rep(8), rep(8), rep(8), rep(8)});
        chk("ones_spacing", {r_cyc[1]-r_cyc[0], r_cyc[2]-r_cyc[1], r_cyc[3]-r_cyc[2]}, {32'd8, 32'd8, 32'd8});
        chk("ones_done_pos", {r_done[0], r_done[1], r_done[2], r_done[3], 4'(done_n)}, {4'b0001, 4'd1});
        chk("ones_busy_at_done", busy_at_done, 1'b0);
        chk("ones_job_cycles", job_cyc, 32);
        chk("ones_rom_walk", {ra[0], ra[1], ra[2], ra[30], ra[31]}, {4'd0, 4'd1, 4'd1, 4'd15, 4'd0});

        // Max operands; 16-bit instance wraps or clamps
        x_data = {4{8'd255}}; coef_const = {7'd127, 7'd127};
        run_job(-1, 0, -1, -1);
        chk("max_data", {r_data[0], r_data[3]}, {rep(18'd259080), rep(18'd259080)});
        chk("max16_data", {r16[0], r16[3]}, {{4{EXP16}}, {4{EXP16}}});
        chk("max16_ovf", ovf16, EXPOVF);
        chk("max18_ovf", ovf, 4'h0);

        // Small job clears the sticky flag at start
        x_data = {4{8'd1}}; coef_const = {7'd1, 7'd1};
        run_job(-1, 0, -1, -1);
        chk("ovf_cleared_on_start", ovf16, 4'h0);
        chk("ones16_data", r16[2], {4{16'd8}});

        // Lane-distinct inputs
        x_data = {8'd4, 8'd3, 8'd2, 8'd1};
        run_job(-1, 0, -1, -1);
        chk("lanes_data", r_data[1], {18'd32, 18'd24, 18'd16, 18'd8});

        // Address-dependent coefficients on even taps only
        x_data = {4{8'd1}}; rom_mode = 1'b1;
        run_job(-1, 0, -1, -1);
        chk("rom_data", {r_data[0], r_data[1], r_data[2], r_data[3]},
            {rep(6), rep(22), rep(38), rep(54)});
        rom_mode = 1'b0;

        // Odd tap half only
        coef_const = {7'd0, 7'd3};
        run_job(-1, 0, -1, -1);
        chk("odd_half_data", r_data[3], rep(12));
        coef_const = {7'd1, 7'd1};

        // Three stall cycles inside result 1
        run_job(12, 3, -1, -1);
        chk("stall_data", {r_data[0], r_data[1], r_data[2], r_data[3]},
            {rep(8), rep(8), rep(8), rep(8)});
        chk("stall_job_cycles", job_cyc, 35);
        chk("stall_rom_hold", {ra[11], ra[12], ra[14], ra[15], ra[16]},
            {4'd6, 4'd6, 4'd6, 4'd6, 4'd7});

        // start while busy is ignored
        run_job(-1, 0, -1, 5);
        chk("start_busy_cycles", job_cyc, 32);
        chk("start_busy_data", r_data[3], rep(8));

        // Abort after 13 accepted taps
        x_data = {4{8'd2}};
        run_job(-1, 0, 13, -1);
        chk("abort_idle", busy, 1'b0);
        chk("abort_events", {4'(we_n), 4'(done_n), 2'(r_idx[0])}, {4'd1, 4'd0, 2'd0});
        chk("abort_res_hold", res_data, rep(16));
        step();
        chk("abort_no_late_we", {res_we, done, busy}, 3'b000);
        x_data = {4{8'd1}};
        run_job(-1, 0, -1, -1);
        chk("after_abort_data", {r_data[0], r_data[3], 4'(we_n)}, {rep(8), rep(8), 4'd4});

        // start+abort together in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 1'b0);
        step();
        chk("start_abort_still_idle", {busy, res_we, done}, 3'b000);

        // Reset mid-job
        we_n = 0; done_n = 0;
        start = 1'b1; step(); start = 1'b0;
        x_valid = 1'b1;
        repeat (11) step();
        #2 rst = 1'b0; #1;
        chk("midrst_outputs", {rom_addr, res_idx, res_we, busy, done, ovf},
            {4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0});
        chk("midrst_res_data", res_data, 72'd0);
        #10 rst = 1'b1;
        repeat (3) step();
        x_valid = 1'b0;
        chk("midrst_stay_idle", {busy, res_we, done, rom_addr}, {3'b000, 4'd0});
        chk("midrst_no_events", {4'(we_n), 4'(done_n)}, {4'd1, 4'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_array.md
# mac_array

Parametrised multiply-accumulate array for the matrix-product datapath: LANES parallel lanes, each forming OUTS dot products of TAPS terms per job between streamed input elements and coefficients read two-per-word from the coefficient ROM. It sits between the input row buffer, which supplies x_data, and the result memory, which res_we/res_idx/res_data write. A start/done job handshake, source back-pressure, abort, and a fixed final-tap accumulation path are included.

## Interface
- LANES, 4: parallel lanes (input rows)
- DATA_W, 8: unsigned input element width
- COEF_W, 7: unsigned coefficient width
- TAPS, 8: products per result; even, ≥2
- OUTS, 4: results per lane per job
- ACC_W, 18: accumulator/result width
- ROM_AW, 4: ROM address width; 2^ROM_AW ≥ OUTS*TAPS/2
- IDX_W, 2: result index width; 2^IDX_W ≥ OUTS
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  job start; sampled in IDLE only
- abort  in  1  synchronous job abort
- x_valid  in  1  x_data holds the current element for all lanes
- x_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- coef_word  in  2*COEF_W  ROM word at rom_addr, same cycle; [2*COEF_W-1:COEF_W] even tap, [COEF_W-1:0] odd tap
- x_take  out  1  combinational; RUN & x_valid; source advances at this edge
- rom_addr  out  ROM_AW  registered coefficient address
- res_data  out  LANES*ACC_W  lane i result at [i*ACC_W +: ACC_W]
- res_idx  out  IDX_W  result index of current res_we
- res_we  out  1  one-cycle result write strobe
- busy  out  1  state == RUN
- done  out  1  one-cycle job-complete pulse
- ovf  out  LANES  per-lane sticky overflow (see Configuration)

## Operation
- States IDLE, RUN. IDLE→RUN on start. RUN→IDLE after the last tap of result OUTS-1, or on abort.
- On entering RUN: tap counter, result counter, rom_addr, accumulators, and ovf cleared.
- Each accepted cycle (x_take=1): lane i computes acc_i + x_i*c. Coefficient c is the even half when tap is even and the odd half when tap is odd. Products are unsigned, zero-extended to ACC_W.
- The tap counter increments. rom_addr increments after each odd tap and wraps modulo 2^ROM_AW.
- x_valid=0 in RUN stalls the block: no accumulation, no counter or address change.
- Tap TAPS-1 accepted: the sum including that product is loaded into res_data, res_idx is set to the result counter, the accumulator clears to 0, the tap counter resets, and the result counter increments. No product is dropped.
- start in RUN is ignored. Simultaneous start and abort in IDLE: abort wins; stay IDLE.
- abort in RUN: next cycle IDLE, accumulators clear, res_we and done stay 0, and res_data holds its last value.
- Without MAC_SAT_EN, accumulation wraps modulo 2^ACC_W.

## Timing
- Reset values: rom_addr=0, res_data=0, res_idx=0, res_we=0, busy=0, done=0, ovf=0, state IDLE.
- start high at edge n: busy=1 and rom_addr=0 from cycle n+1. The first accumulation happens at the first edge with x_valid=1 after that.
- res_we, res_idx, and res_data are registered. They are valid in the cycle after the edge that accepts the final tap; res_we is high for exactly one cycle.
- done is asserted in the same cycle as the res_we for res_idx=OUTS-1. busy=0 in that cycle.
- Job length with no stalls: OUTS*TAPS accepted cycles (32 at defaults). Each stall cycle adds 1.
- A new start is accepted in the cycle done is high (state is IDLE).
- Reset asserted mid-job: everything returns to reset values immediately; no res_we or done is issued.

## Configuration
- MAC_SAT_EN defined: the per-lane accumulator clamps to 2^ACC_W-1 when the true sum exceeds it. The clamped value continues to accumulate (it stays clamped) until the end of the result. ovf[i] is set on the first clamp and stays set until the next start.
- MAC_SAT_EN undefined: accumulation wraps modulo 2^ACC_W, and ovf is tied to 0.

## Test plan
- Defaults, all x=1, all coef=1, x_valid held high: four res_we pulses 8 cycles apart, res_idx 0..3, every lane result=8. done coincides with res_idx=3. rom_addr walks 0..15 and wraps to 0.
- Defaults, x=255, coef=127 on all taps: every result=259080. Lane-distinct x (lane i = i+1) with coef=1 gives results 8, 16, 24, 32.
- x_valid low for 3 cycles in the middle of result 1: results are identical to the no-stall run, the job takes 35 cycles, and rom_addr holds during the stall.
- abort after 13 accepted taps: IDLE next cycle; only one res_we seen (idx 0), no done. A following job with all-1 data gives correct results of 8.
- ACC_W=16, x=255, coef=127: without MAC_SAT_EN, result=62472 and ovf=0. With MAC_SAT_EN, result=65535 and ovf=all ones, and ovf clears on the next start.
- rst deasserted→asserted during RUN, then released: all outputs are at reset values. start is ignored while busy, and start+abort together in IDLE stays IDLE.
